matmul_share_arbiter: RTL

- Shares one sequential 2x2 matrix-multiply engine (8-bit operands, 16-bit results, start/done level handshake) between NUM_REQ requesters.
- Round-robin arbitration. The granted job's operands are latched and the engine is sequenced through start, done and release.
- The packed result is returned to the winning requester on a valid/ready response channel tagged with the requester id.
- Sits between the accelerator front-end ports and the single multiplier instance.

---
 rtl/matmul_share_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/matmul_share_arbiter.sv
// matmul_share_arbiter
//   Round-robin share of one sequential 2x2 matrix-multiply engine between
//   NUM_REQ requesters. A granted job's operands are latched, the engine is
//   walked through start -> done -> release, and the captured result is
//   returned on a valid/ready response channel tagged with the requester id.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b          slice i = [32*i +: 32] = {x22,x21,x12,x11}, 8b each
//   mm_start/mm_done     level handshake to the engine
//   mm_a/mm_b/mm_c       latched operands out, 64b result {c22,c21,c12,c11} in
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_c/rsp_err served requester, captured result, watchdog flag
//
// Optional feature macro: MATMUL_TIMEOUT_EN
//   Adds a TIMEOUT_CYCLES watchdog on the ISSUE state. When it fires, the
//   result is zeroed and rsp_err is raised. Without it rsp_err is tied 0.

module matmul_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 mm_start,
  output logic [31:0]          mm_a,
  output logic [31:0]          mm_b,
  input  logic [63:0]          mm_c,
  input  logic                 mm_done,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [63:0]          rsp_c,
  output logic                 rsp_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("matmul_share_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_idx;
  logic            win_found;
  logic            grant;
  logic            tmo_hit;

  // Round-robin pick: the second pass (indices >= rr_ptr) overrides the
  // first (any index), so the wrap to index 0 only wins when nothing at or
  // above the pointer is requesting.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win_idx   = ID_W'(i);
      end
    end
  end

  assign grant = (state == IDLE) && win_found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = (state == IDLE) && win_found &&
                          (win_idx == ID_W'(i)) && req_valid[i];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state. DRAIN waits for the engine to drop done so a new grant can
  // never see a stale done from the previous job.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)               state_nxt = ISSUE;
      ISSUE:   if (mm_done || tmo_hit)  state_nxt = DRAIN;
      DRAIN:   if (!mm_done)            state_nxt = RESP;
      RESP:    if (rsp_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Datapath / registered outputs. mm_done in IDLE is deliberately ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      mm_start  <= 1'b0;
      mm_a      <= '0;
      mm_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
    end else begin
      unique case (state)
        IDLE: if (grant) begin
          mm_a     <= req_a[32*win_idx +: 32];
          mm_b     <= req_b[32*win_idx +: 32];
          rsp_id   <= win_idx;
          rr_ptr   <= (win_idx == LAST_ID) ? '0 : win_idx + ID_W'(1);
          mm_start <= 1'b1;
        end
        ISSUE: if (mm_done) begin
          rsp_c    <= mm_c;
          mm_start <= 1'b0;
        end else if (tmo_hit) begin
          rsp_c    <= '0;
          mm_start <= 1'b0;
        end
        DRAIN: if (!mm_done) rsp_valid <= 1'b1;
        RESP:  if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MATMUL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  // Fires on the TIMEOUT_CYCLES-th consecutive ISSUE cycle without done.
  assign tmo_hit = (state == ISSUE) && !mm_done &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != ISSUE)      tmo_cnt <= '0;
      else if (!mm_done)       tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_hit)                          err_q <= 1'b1;
      else if (state == RESP && rsp_ready)  err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule
